// File: rtl/sap1_pkg.sv
// Shared constants and types for the SAP-1 MAR/RAM block.
// Holds the bus geometry, the program-mode FSM states and the released-bus value.
package sap1_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } prog_state_e;

  localparam logic [DATA_W-1:0] BUS_Z = {DATA_W{1'bz}};

endpackage

// File: rtl/sap1_ram16x8.sv
// SAP-1 program/data store: one falling-edge write port and one asynchronous read port.
// Contents are deliberately not reset so a program loaded from the switches survives a reset.
module sap1_ram16x8 #(
  parameter int unsigned ADDR_W = sap1_pkg::ADDR_W,
  parameter int unsigned DATA_W = sap1_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [Depth];

  always_ff @(negedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap1_mar_ram.sv
// SAP-1 memory address register plus 16x8 RAM with a front-panel program mode.
// All state changes on the falling clock edge; the W-bus drive is purely combinational.
module sap1_mar_ram #(
  parameter int unsigned ADDR_W = sap1_pkg::ADDR_W,
  parameter int unsigned DATA_W = sap1_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Lm,
  input  logic              Lr,
  input  logic              CE,
  input  logic [DATA_W-1:0] wbus_in,
  output logic [DATA_W-1:0] wbus_out,
  input  logic              prog,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_we,
  output logic              prog_done,
  output logic [ADDR_W-1:0] mar
);

  import sap1_pkg::*;

  logic [ADDR_W-1:0] mar_q, mar_d;
  prog_state_e       state_q, state_d;
  logic              we_q;
  logic              prog_done_q, prog_done_d;
  logic              rise;

  logic              prog_commit;
  logic              run_write;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic              drive;

  assign rise = prog_we & ~we_q;

  // One commit per switch press: HOLD parks the FSM until the switch is released.
  always_comb begin
    state_d     = state_q;
    prog_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (prog && rise) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d     = HOLD;
        prog_done_d = 1'b1;
      end
      HOLD: begin
        if (!prog_we || !prog) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mar_d = mar_q;
    if (!prog && Lm) begin
      mar_d = wbus_in[ADDR_W-1:0];
    end
  end

  // The commit edge of WRITE also fires if prog has already dropped.
  assign prog_commit = (state_q == WRITE);
  // CE wins over Lr so the RAM never samples its own drive.
  assign run_write   = !prog && Lr && !CE;

  always_comb begin
    ram_we    = prog_commit | run_write;
    ram_waddr = mar_q;
    ram_wdata = wbus_in;
    if (prog_commit) begin
      ram_waddr = prog_addr;
      ram_wdata = prog_data;
    end
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      mar_q       <= '0;
      state_q     <= IDLE;
      we_q        <= 1'b0;
      prog_done_q <= 1'b0;
    end else begin
      mar_q       <= mar_d;
      state_q     <= state_d;
      we_q        <= prog_we;
      prog_done_q <= prog_done_d;
    end
  end

  assign ram_raddr = prog ? prog_addr : mar_q;

  sap1_ram16x8 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign drive     = CE && !prog;
  assign wbus_out  = drive ? ram_rdata : BUS_Z;
  assign prog_done = prog_done_q;
  assign mar       = mar_q;

endmodule

// File: tb/tb_sap1_mar_ram.sv
// Self-checking bench for sap1_mar_ram: directed vector table, hand-written corner
// sequences, then randomized traffic against a press/commit level memory model.
module tb_sap1_mar_ram;

  logic       clock     = 1'b0;
  logic       reset     = 1'b0;
  logic       Lm        = 1'b0;
  logic       Lr        = 1'b0;
  logic       CE        = 1'b0;
  logic [7:0] wbus_in   = 8'h00;
  logic       prog      = 1'b0;
  logic [3:0] prog_addr = 4'h0;
  logic [7:0] prog_data = 8'h00;
  logic       prog_we   = 1'b0;
  wire  [7:0] wbus_out;
  wire        prog_done;
  wire  [3:0] mar;

  wire bus_z = (wbus_out === 8'bzzzzzzzz);

  int checks = 0;
  int errors = 0;

  sap1_mar_ram dut (
    .clock     (clock),
    .reset     (reset),
    .Lm        (Lm),
    .Lr        (Lr),
    .CE        (CE),
    .wbus_in   (wbus_in),
    .wbus_out  (wbus_out),
    .prog      (prog),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_we   (prog_we),
    .prog_done (prog_done),
    .mar       (mar)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       prog, lm, lr, ce, we;
    logic [7:0] wb;
    logic [3:0] pa;
    logic [7:0] pd;
    logic [3:0] e_mar;
    logic       e_done;
    logic       e_z;
    logic [7:0] e_bus;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic p, input logic lm, input logic lr, input logic ce,
                              input logic we, input logic [7:0] wb, input logic [3:0] pa,
                              input logic [7:0] pd, input logic [3:0] e_mar, input logic e_done,
                              input logic e_z, input logic [7:0] e_bus);
    vec_t v;
    v.prog = p;  v.lm = lm; v.lr = lr; v.ce = ce; v.we = we;
    v.wb = wb;   v.pa = pa; v.pd = pd;
    v.e_mar = e_mar; v.e_done = e_done; v.e_z = e_z; v.e_bus = e_bus;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bus(input string name, input logic e_z, input logic [7:0] e_val);
    logic ok;
    checks++;
    if (e_z) ok = bus_z;
    else     ok = !bus_z && (wbus_out == e_val);
    if (!ok) begin
      errors++;
      $display("FAIL %s: bus=%h released=%0b expected %s (t=%0t)", name, wbus_out, bus_z,
               e_z ? "z" : $sformatf("%h", e_val), $time);
    end
  endtask

  task automatic edge_chk(input string name, input logic [3:0] e_mar, input logic e_done,
                          input logic e_z, input logic [7:0] e_bus);
    @(negedge clock);
    #1;
    check({name, ".mar"}, mar, e_mar);
    check({name, ".done"}, prog_done, e_done);
    check_bus({name, ".bus"}, e_z, e_bus);
  endtask

  task automatic do_reset();
    {Lm, Lr, CE, prog, prog_we} = '0;
    reset = 1'b0;
    @(negedge clock);
    #1;
    check("rst.mar", mar, 4'h0);
    check("rst.done", prog_done, 1'b0);
    check_bus("rst.bus", 1'b1, 8'h00);
    reset = 1'b1;
  endtask

  // Reference model: tracks switch presses and their single commit, not the RTL states.
  logic [7:0] m_mem[16];
  bit         m_known[16];
  logic [3:0] m_mar;
  bit         m_pending, m_hold, m_done, m_weprev;

  task automatic model_edge();
    bit rise;
    rise   = prog_we && !m_weprev;
    m_done = 1'b0;
    if (m_pending) begin
      m_mem[prog_addr]   = prog_data;
      m_known[prog_addr] = 1'b1;
      m_pending = 1'b0;
      m_done    = 1'b1;
      m_hold    = 1'b1;
    end else if (m_hold) begin
      if (!prog_we || !prog) m_hold = 1'b0;
    end else if (prog && rise) begin
      m_pending = 1'b1;
    end
    if (!prog && Lr && !CE) begin
      m_mem[m_mar]   = wbus_in;
      m_known[m_mar] = 1'b1;
    end
    if (!prog && Lm) m_mar = wbus_in[3:0];
    m_weprev = prog_we;
  endtask

  task automatic rand_step();
    @(negedge clock);
    model_edge();
    #1;
    check("rnd.mar", mar, m_mar);
    check("rnd.done", prog_done, m_done);
    if (CE && !prog) begin
      if (m_known[m_mar]) check_bus("rnd.rd", 1'b0, m_mem[m_mar]);
    end else begin
      check_bus("rnd.z", 1'b1, 8'h00);
    end
  endtask

  initial begin
    do_reset();

    // Held press, second press, run reads, simultaneous controls, program isolation.
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 1, 1, 1, 1, 8'hFF, 4'h3, 8'hA5, 4'h0, (i == 1), 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 4'hF, 8'h3C, 4'h0, 0, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 1, 8'h00, 4'hF, 8'h3C, 4'h0, 0, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 1, 8'h00, 4'hF, 8'h3C, 4'h0, 1, 1, 8'h00));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 4'hF, 8'h3C, 4'h0, 0, 1, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h03, 4'h0, 8'h00, 4'h3, 0, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h03, 4'h0, 8'h00, 4'h3, 0, 0, 8'hA5));
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'hFF, 4'h0, 8'h00, 4'hF, 0, 0, 8'h3C));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'h03, 4'h0, 8'h00, 4'h3, 0, 1, 8'h00));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'h07, 4'h0, 8'h00, 4'h7, 0, 1, 8'h00));
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'h03, 4'h0, 8'h00, 4'h3, 0, 0, 8'h07));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'h99, 4'h0, 8'h00, 4'h3, 0, 0, 8'h07));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h99, 4'h0, 8'h00, 4'h3, 0, 0, 8'h07));
    vecs.push_back(mk(1, 1, 1, 1, 0, 8'h0F, 4'h3, 8'h00, 4'h3, 0, 1, 8'h00));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'h0F, 4'h3, 8'h00, 4'h3, 0, 0, 8'h07));

    foreach (vecs[i]) begin
      prog = vecs[i].prog; Lm = vecs[i].lm; Lr = vecs[i].lr; CE = vecs[i].ce;
      prog_we = vecs[i].we; wbus_in = vecs[i].wb;
      prog_addr = vecs[i].pa; prog_data = vecs[i].pd;
      edge_chk($sformatf("vec%0d", i), vecs[i].e_mar, vecs[i].e_done, vecs[i].e_z,
               vecs[i].e_bus);
    end

    // prog drops while the write is pending: the write still lands.
    {Lm, Lr, CE} = '0;
    prog = 1'b1; prog_addr = 4'h5; prog_data = 8'hC3; prog_we = 1'b1;
    edge_chk("drop.arm", 4'h3, 1'b0, 1'b1, 8'h00);
    prog = 1'b0;
    edge_chk("drop.commit", 4'h3, 1'b1, 1'b1, 8'h00);
    prog_we = 1'b0; Lm = 1'b1; wbus_in = 8'h05; CE = 1'b1;
    edge_chk("drop.read", 4'h5, 1'b0, 1'b0, 8'hC3);

    // Reset lands between arming and commit: RAM[3] must keep 8'h07.
    Lm = 1'b0; CE = 1'b0;
    prog = 1'b1; prog_addr = 4'h3; prog_data = 8'h5A; prog_we = 1'b1;
    edge_chk("abort.arm", 4'h5, 1'b0, 1'b1, 8'h00);
    #2 reset = 1'b0;
    #1;
    check("abort.rst_mar", mar, 4'h0);
    check("abort.rst_done", prog_done, 1'b0);
    prog_we = 1'b0;
    @(negedge clock);
    #1;
    check("abort.edge_done", prog_done, 1'b0);
    reset = 1'b1;
    prog = 1'b0; Lm = 1'b1; CE = 1'b1; wbus_in = 8'h03;
    edge_chk("abort.rd3", 4'h3, 1'b0, 1'b0, 8'h07);
    wbus_in = 8'h0F;
    edge_chk("abort.rdF", 4'hF, 1'b0, 1'b0, 8'h3C);
    wbus_in = 8'h05;
    edge_chk("abort.rd5", 4'h5, 1'b0, 1'b0, 8'hC3);

    // Randomized traffic against the model.
    do_reset();
    foreach (m_known[i]) m_known[i] = 1'b0;
    m_mem[3] = 8'h07; m_known[3] = 1'b1;
    m_mem[5] = 8'hC3; m_known[5] = 1'b1;
    m_mem[15] = 8'h3C; m_known[15] = 1'b1;
    m_mar = 4'h0; m_pending = 1'b0; m_hold = 1'b0; m_done = 1'b0; m_weprev = 1'b0;

    for (int ph = 0; ph < 10; ph++) begin
      prog = ph[0];
      for (int c = 0; c < 40; c++) begin
        Lm = 1'($urandom_range(0, 1));
        Lr = 1'($urandom_range(0, 1));
        CE = 1'($urandom_range(0, 1));
        wbus_in   = 8'($urandom);
        prog_addr = 4'($urandom);
        prog_data = 8'($urandom);
        if ($urandom_range(0, 2) == 0) prog_we = ~prog_we;
        rand_step();
      end
      if (prog) begin
        // Let any press in flight finish before leaving program mode.
        prog_we = 1'b0;
        repeat (3) rand_step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
